// File: rtl/daio_rx_sequencer.sv
// DAIO receive sequencer: tracks preambles, subframe A/B bit slots and block position,
// and drives the shift/parity/load strobes of the receive datapath.
module daio_rx_sequencer #(
  parameter int BITS_PER_SUB     = 28,
  parameter int FRAMES_PER_BLOCK = 192,
  parameter int FC_W             = 9
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            bit_valid,
  input  logic            bit_in,
  input  logic            preamble_1,
  input  logic            preamble_2,
  input  logic            preamble_3,
  input  logic            carrier_loss,
  output logic [3:0]      state,
  output logic            shift_en,
  output logic            parity_clr,
  output logic            load_A,
  output logic            load_B,
  output logic            load_buff,
  output logic [FC_W-1:0] frame_counter,
  output logic            lock,
  output logic            parity_err,
  output logic            sync_err
);

  localparam int BC_W = $clog2(BITS_PER_SUB + 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    HUNT   = 4'd1,
    RX_A   = 4'd2,
    END_A  = 4'd3,
    WAIT_B = 4'd4,
    RX_B   = 4'd5,
    END_B  = 4'd6,
    WAIT_A = 4'd7
  } state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   bit_count_q, bit_count_d;
  logic              parity_q, parity_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic              lock_q, lock_d;
  logic              perr_q, perr_d;
  logic              serr_q, serr_d;
  logic              accept;
  logic              any_pre, only_p1, only_p2, only_p3;

  // Exactly one pulse is required for a preamble to count as a match.
  assign any_pre = preamble_1 | preamble_2 | preamble_3;
  assign only_p1 = preamble_1 & ~preamble_2 & ~preamble_3;
  assign only_p2 = preamble_2 & ~preamble_1 & ~preamble_3;
  assign only_p3 = preamble_3 & ~preamble_1 & ~preamble_2;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    bit_count_d = bit_count_q;
    parity_d    = parity_q;
    fc_d        = fc_q;
    lock_d      = lock_q;
    perr_d      = perr_q;
    serr_d      = serr_q;
    accept      = 1'b0;
    shift_en    = 1'b0;
    parity_clr  = 1'b0;
    load_A      = 1'b0;
    load_B      = 1'b0;
    load_buff   = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      lock_d  = 1'b0;
    end else if (carrier_loss && state_q != IDLE) begin
      state_d = HUNT;
      lock_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (only_p1) begin
            state_d = RX_A;
            fc_d    = '0;
            accept  = 1'b1;
          end
        end
        RX_A, RX_B: begin
          if (any_pre) begin
            serr_d  = 1'b1;
            lock_d  = 1'b0;
            state_d = HUNT;
          end else if (bit_valid) begin
            shift_en    = 1'b1;
            parity_d    = parity_q ^ bit_in;
            bit_count_d = bit_count_q + BC_W'(1);
            if (bit_count_q == BC_W'(BITS_PER_SUB - 1))
              state_d = (state_q == RX_A) ? END_A : END_B;
          end
        end
        END_A: begin
          if (parity_q) perr_d = 1'b1;
          else          load_A = 1'b1;
          state_d = WAIT_B;
        end
        END_B: begin
          if (parity_q) perr_d = 1'b1;
          else          load_B = 1'b1;
          lock_d = 1'b1;
          if (fc_q == FC_W'(FRAMES_PER_BLOCK - 1)) begin
            load_buff = 1'b1;
            fc_d      = '0;
          end else begin
            fc_d = fc_q + FC_W'(1);
          end
          state_d = WAIT_A;
        end
        WAIT_B: begin
          if (only_p3) begin
            state_d = RX_B;
            accept  = 1'b1;
          end else if (any_pre) begin
            serr_d  = 1'b1;
            lock_d  = 1'b0;
            state_d = HUNT;
          end
        end
        WAIT_A: begin
          // Frame 0 of a block opens with preamble_1, every other frame with preamble_2.
          if ((fc_q == '0) ? only_p1 : only_p2) begin
            state_d = RX_A;
            accept  = 1'b1;
          end else if (any_pre) begin
            serr_d  = 1'b1;
            lock_d  = 1'b0;
            state_d = HUNT;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (accept) begin
      parity_clr  = 1'b1;
      bit_count_d = '0;
      parity_d    = 1'b0;
    end

    if (!reset) begin
      shift_en   = 1'b0;
      parity_clr = 1'b0;
      load_A     = 1'b0;
      load_B     = 1'b0;
      load_buff  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_count_q <= '0;
      parity_q    <= 1'b0;
      fc_q        <= '0;
      lock_q      <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      parity_q    <= parity_d;
      fc_q        <= fc_d;
      lock_q      <= lock_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
    end
  end

  assign state         = state_q;
  assign frame_counter = fc_q;
  assign lock          = lock_q;
  assign parity_err    = perr_q;
  assign sync_err      = serr_q;

endmodule

// File: tb/tb_daio_rx_sequencer.sv
// Directed/randomised bench for daio_rx_sequencer: whole frames are sent and the
// expected strobe counts, flags and frame index are predicted from the frame contents.
module tb_daio_rx_sequencer;

  logic       clock = 1'b0;
  logic       reset, enable, bit_valid, bit_in;
  logic       preamble_1, preamble_2, preamble_3, carrier_loss;
  logic [3:0] state;
  logic       shift_en, parity_clr, load_A, load_B, load_buff;
  logic [8:0] frame_counter;
  logic       lock, parity_err, sync_err;

  daio_rx_sequencer dut (
    .clock(clock), .reset(reset), .enable(enable), .bit_valid(bit_valid), .bit_in(bit_in),
    .preamble_1(preamble_1), .preamble_2(preamble_2), .preamble_3(preamble_3),
    .carrier_loss(carrier_loss), .state(state), .shift_en(shift_en), .parity_clr(parity_clr),
    .load_A(load_A), .load_B(load_B), .load_buff(load_buff), .frame_counter(frame_counter),
    .lock(lock), .parity_err(parity_err), .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe observations, taken on the falling edge away from the active edge.
  int cnt_a = 0, cnt_b = 0, cnt_buff = 0, cnt_shift = 0, viol = 0, buff_fc = -1;

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (load_A)    begin cnt_a++;    if (state != 4'd3) viol++; end
      if (load_B)    begin cnt_b++;    if (state != 4'd6) viol++; end
      if (load_buff) begin cnt_buff++; buff_fc = int'(frame_counter); if (state != 4'd6) viol++; end
      if (shift_en)  cnt_shift++;
      if ((state == 4'd0 || state == 4'd1) && (shift_en | load_A | load_B | load_buff)) viol++;
    end
  end

  // Reference model state.
  int exp_a = 0, exp_b = 0, exp_buff = 0, exp_shift = 0, exp_fc = 0;
  bit exp_perr = 0, exp_lock = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    bit_valid = 0; bit_in = 0; preamble_1 = 0; preamble_2 = 0; preamble_3 = 0; carrier_loss = 0;
  endtask

  // Cycles outside RX states: random bit_valid must be ignored there.
  task automatic gap();
    repeat (1 + $urandom_range(0, 1)) begin
      idle_in();
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom);
      tick();
    end
    idle_in();
  endtask

  task automatic pulse(input int which, input bit with_bit);
    idle_in();
    preamble_1 = (which == 1);
    preamble_2 = (which == 2);
    preamble_3 = (which == 3);
    bit_valid  = with_bit;
    bit_in     = 1'($urandom);
    tick();
    idle_in();
  endtask

  task automatic send_bits(input logic [27:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      idle_in();
      bit_valid = 1;
      bit_in    = d[i];
      tick();
      idle_in();
      repeat ($urandom_range(0, 1)) tick();
    end
    exp_shift += n;
  endtask

  function automatic logic [27:0] rand_even();
    logic [27:0] d;
    d     = 28'($urandom);
    d[27] = ^d[26:0];
    return d;
  endfunction

  task automatic send_frame(input int pre_a, input logic [27:0] a, input logic [27:0] b);
    pulse(pre_a, 1'($urandom_range(0, 1)));
    send_bits(a, 28);
    gap();
    if ((^a) == 1'b0) exp_a++; else exp_perr = 1;
    pulse(3, 1'($urandom_range(0, 1)));
    send_bits(b, 28);
    gap();
    if ((^b) == 1'b0) exp_b++; else exp_perr = 1;
    exp_lock = 1;
    if (exp_fc == 191) begin exp_buff++; exp_fc = 0; end
    else exp_fc++;
  endtask

  logic [27:0] d;

  initial begin
    idle_in();
    enable = 0;
    reset  = 0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      enable = 1'($urandom); bit_valid = 1'($urandom); bit_in = 1'($urandom);
      preamble_1 = 1'($urandom); preamble_2 = 1'($urandom); preamble_3 = 1'($urandom);
      carrier_loss = 1'($urandom);
      tick();
      check("rst_state", state, 0);
      check("rst_outs", {shift_en, parity_clr, load_A, load_B, load_buff, lock, parity_err, sync_err}, 0);
      check("rst_fc", frame_counter, 0);
    end

    idle_in();
    reset  = 1;
    enable = 1;
    tick();
    check("idle_to_hunt", state, 1);

    // HUNT ignores preamble_2 and bits.
    pulse(2, 1);
    check("hunt_ignore_p2", state, 1);
    check("hunt_no_shift", cnt_shift, 0);

    // First frame, all zeros.
    send_frame(1, 28'd0, 28'd0);
    check("f0_load_a", cnt_a, 1);
    check("f0_load_b", cnt_b, 1);
    check("f0_lock", lock, 1);
    check("f0_fc", frame_counter, 1);
    check("f0_perr", parity_err, 0);
    check("f0_state_wait_a", state, 7);

    // Rest of the block.
    for (int f = 1; f < 192; f++) send_frame(2, rand_even(), rand_even());
    check("blk_load_a", cnt_a, exp_a);
    check("blk_load_a_192", cnt_a, 192);
    check("blk_load_b", cnt_b, exp_b);
    check("blk_load_buff", cnt_buff, 1);
    check("blk_buff_at_191", buff_fc, 191);
    check("blk_fc_wrap", frame_counter, exp_fc);
    check("blk_shift", cnt_shift, exp_shift);
    check("blk_perr", parity_err, 0);

    // Subframe A with wrong parity bit.
    d = rand_even();
    d[27] = ~d[27];
    send_frame(1, d, rand_even());
    check("perr_no_load_a", cnt_a, exp_a);
    check("perr_load_b", cnt_b, exp_b);
    check("perr_flag", parity_err, 1);
    check("perr_fc", frame_counter, exp_fc);
    check("perr_no_serr", sync_err, 0);

    // preamble_2 in WAIT_B.
    pulse(2, 0);
    send_bits(rand_even(), 28);
    gap();
    exp_a++;
    check("wb_state_wait_b", state, 4);
    pulse(2, 1);
    exp_lock = 0;
    check("wb_p2_hunt", state, 1);
    check("wb_p2_serr", sync_err, 1);
    check("wb_p2_lock", lock, exp_lock);
    check("wb_fc_held", frame_counter, exp_fc);

    // Resynchronise on preamble_1.
    pulse(1, 0);
    check("resync_rx_a", state, 2);
    check("resync_fc0", frame_counter, 0);
    exp_fc = 0;
    send_bits(rand_even(), 28); gap(); exp_a++;
    pulse(3, 0);
    send_bits(rand_even(), 28); gap(); exp_b++; exp_fc = 1; exp_lock = 1;
    check("resync_fc1", frame_counter, exp_fc);
    check("resync_lock", lock, exp_lock);

    // preamble_3 at bit 10 of RX_A; the coincident bit is dropped.
    pulse(2, 0);
    send_bits(rand_even(), 10);
    pulse(3, 1);
    exp_lock = 0;
    check("rxa_p3_hunt", state, 1);
    check("rxa_p3_lock", lock, exp_lock);
    check("rxa_p3_shift", cnt_shift, exp_shift);
    check("rxa_p3_no_load", cnt_a, exp_a);

    // Wrong preamble in WAIT_A (frame 1 expects preamble_2).
    exp_fc = 0;
    send_frame(1, rand_even(), rand_even());
    check("wa_fc", frame_counter, exp_fc);
    pulse(1, 0);
    check("wa_p1_hunt", state, 1);

    // Carrier loss mid RX_B.
    exp_fc = 0;
    pulse(1, 0);
    send_bits(rand_even(), 28); gap(); exp_a++;
    pulse(3, 0);
    send_bits(rand_even(), 12);
    carrier_loss = 1; bit_valid = 1; bit_in = 1;
    tick();
    idle_in();
    check("cl_hunt", state, 1);
    check("cl_lock", lock, 0);
    repeat (40) begin
      bit_valid = 1'($urandom); bit_in = 1'($urandom);
      tick();
    end
    idle_in();
    check("cl_no_load_b", cnt_b, exp_b);
    check("cl_shift", cnt_shift, exp_shift);
    check("cl_still_hunt", state, 1);

    // Enable dropped.
    enable = 0;
    tick();
    check("en_idle", state, 0);
    check("en_perr_held", parity_err, 1);
    check("en_serr_held", sync_err, 1);

    // Reset mid-block.
    enable = 1;
    tick();
    exp_fc = 0;
    send_frame(1, rand_even(), rand_even());
    pulse(2, 0);
    send_bits(rand_even(), 5);
    check("pre_rst_fc", frame_counter, 1);
    reset = 0; bit_valid = 1;
    tick();
    idle_in();
    check("mid_rst_state", state, 0);
    check("mid_rst_fc", frame_counter, 0);
    check("mid_rst_outs", {shift_en, parity_clr, load_A, load_B, load_buff, lock, parity_err, sync_err}, 0);
    reset = 1;
    tick();

    check("final_load_a", cnt_a, exp_a);
    check("final_load_b", cnt_b, exp_b);
    check("strobe_rules", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
